// File: rtl/lsu_mem_ctrl.sv
// Load/store initiator: turns RV32I byte/half/word requests into cycles on a word-addressed data memory.
// Define LSU_STATS_EN to add per-class completion counters (stat_loads/stat_stores/stat_errs).
module lsu_mem_ctrl #(
  parameter int MEM_WORDS = 128
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_read_en,
  output logic        mem_write_en,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out
`ifdef LSU_STATS_EN
  ,
  output logic [31:0] stat_loads,
  output logic [31:0] stat_stores,
  output logic [31:0] stat_errs
`endif
);

  // state    | meaning
  // S_IDLE   | waiting for a request, req_ready high
  // S_LOAD   | memory read, word captured at the edge
  // S_RMW_RD | read of the word a sub-word store will patch
  // S_STORE  | memory write of the full or merged word
  // S_DONE   | one-cycle response pulse
  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_RMW_RD, S_STORE, S_DONE
  } state_t;

  state_t      state, state_nxt;
  logic        accept;
  logic        req_bad;
  logic [31:0] addr_q;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [15:0] wdata_q;
  logic        err_q;
  logic [31:0] word_q;
  logic [31:0] merged;
  logic [31:0] shifted;
  logic [31:0] load_ext;

  assign accept = req_valid && req_ready;

  always_comb begin
    req_bad = 1'b0;
    case (req_funct3)
      3'b000:  req_bad = 1'b0;
      3'b001:  req_bad = req_addr[0];
      3'b010:  req_bad = |req_addr[1:0];
      3'b100:  req_bad = req_we;
      3'b101:  req_bad = req_we | req_addr[0];
      default: req_bad = 1'b1;
    endcase
    if (req_addr[31:2] >= 30'(MEM_WORDS))
      req_bad = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (req_bad)                    state_nxt = S_DONE;
          else if (!req_we)               state_nxt = S_LOAD;
          else if (req_funct3 == 3'b010)  state_nxt = S_STORE;
          else                            state_nxt = S_RMW_RD;
        end
      end
      S_LOAD:   state_nxt = S_DONE;
      S_RMW_RD: state_nxt = S_STORE;
      S_STORE:  state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // word_q holds the SW data from accept, or the word read in LOAD / merged in RMW_RD
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q   <= '0;
      we_q     <= 1'b0;
      funct3_q <= '0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
      word_q   <= '0;
    end else if (accept) begin
      addr_q   <= req_addr;
      we_q     <= req_we;
      funct3_q <= req_funct3;
      wdata_q  <= req_wdata[15:0];
      err_q    <= req_bad;
      word_q   <= req_wdata;
    end else if (state == S_LOAD) begin
      word_q <= mem_data_out;
    end else if (state == S_RMW_RD) begin
      word_q <= merged;
    end
  end

  always_comb begin
    merged = mem_data_out;
    if (funct3_q[1:0] == 2'b00)
      merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    else
      merged[{addr_q[1], 4'b0000} +: 16] = wdata_q;
  end

  always_comb begin
    shifted = word_q >> {addr_q[1:0], 3'b000};
    case (funct3_q)
      3'b000:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_ext = {24'h0, shifted[7:0]};
      3'b101:  load_ext = {16'h0, shifted[15:0]};
      default: load_ext = word_q;
    endcase
  end

  // all outputs held low while rst is asserted, whatever the state
  always_comb begin
    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    resp_rdata   = '0;
    resp_err     = 1'b0;
    mem_read_en  = 1'b0;
    mem_write_en = 1'b0;
    mem_address  = '0;
    mem_data_in  = '0;
    if (!rst) begin
      case (state)
        S_IDLE: req_ready = 1'b1;
        S_LOAD, S_RMW_RD: begin
          mem_read_en = 1'b1;
          mem_address = {addr_q[31:2], 2'b00};
        end
        S_STORE: begin
          mem_write_en = 1'b1;
          mem_address  = {addr_q[31:2], 2'b00};
          mem_data_in  = word_q;
        end
        S_DONE: begin
          resp_valid = 1'b1;
          resp_err   = err_q;
          resp_rdata = (err_q || we_q) ? 32'h0 : load_ext;
        end
        default: ;
      endcase
    end
  end

`ifdef LSU_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_loads  <= '0;
      stat_stores <= '0;
      stat_errs   <= '0;
    end else if (state == S_DONE) begin
      if (err_q)     stat_errs   <= stat_errs + 32'd1;
      else if (we_q) stat_stores <= stat_stores + 32'd1;
      else           stat_loads  <= stat_loads + 32'd1;
    end
  end
`endif

endmodule
